// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: requester and master-FSM side signals of the I2C master arbiter
interface i2c_master_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_SIZE = 8
);
   logic [NUM_REQ-1:0] req_i, lock_i, gnt_o, done_o, nack_o, timeout_o;
   logic [NUM_REQ*ADDR_SIZE-1:0] slave_addr_rw_i;
   logic [ADDR_SIZE-1:0] slave_addr_rw_o;
   logic done_i, nack_i, enable_o, repeat_start_o, stop_o, rw_o;
   modport slave (
      input req_i, slave_addr_rw_i, lock_i, done_i, nack_i,
      output gnt_o, enable_o, repeat_start_o, stop_o, rw_o, slave_addr_rw_o, done_o, nack_o, timeout_o
   );
   modport master (
      output req_i, slave_addr_rw_i, lock_i, done_i, nack_i,
      input gnt_o, enable_o, repeat_start_o, stop_o, rw_o, slave_addr_rw_o, done_o, nack_o, timeout_o
   );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one I2C master, grant held across repeated START
module i2c_master_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT = 4096
) (
   input logic i2c_core_clk_i,
   input logic reset_ni,
   i2c_master_arbiter_if.slave bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_e;
   state_e state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d, pick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, nack_q, nack_d, to_q, to_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic lock_q, lock_d, en_q, en_d, rs_q, rs_d, stop_q, stop_d, rel, term;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p, input int i);
      int s;
      s = int'(p) + i;
      return PW'(s >= NUM_REQ ? s - NUM_REQ : s);
   endfunction
   assign term = cnt_q == CW'(TIMEOUT - 1);
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      gnt_d = gnt_q;
      addr_d = addr_q;
      lock_d = lock_q;
      en_d = 1'b0;
      rs_d = 1'b0;
      stop_d = 1'b0;
      done_d = '0;
      nack_d = '0;
      to_d = '0;
      rel = 1'b0;
      pick = ptr_q;
      // descending scan so the nearest requester after the pointer wins
      for (int i = NUM_REQ; i >= 1; i--)
         if (bus.req_i[nxt(ptr_q, i)]) pick = nxt(ptr_q, i);
      unique case (state_q)
         IDLE: if (|bus.req_i) begin
            gnt_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            addr_d = bus.slave_addr_rw_i[int'(pick)*ADDR_SIZE +: ADDR_SIZE];
            lock_d = bus.lock_i[pick];
            ptr_d = pick;
            en_d = 1'b1;
            cnt_d = '0;
            state_d = ACTIVE;
         end
         ACTIVE: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.done_i) begin
               done_d = gnt_q;
               nack_d = bus.nack_i ? gnt_q : '0;
               cnt_d = '0;
               state_d = HOLD;
               rel = !lock_q || bus.nack_i;
            end else if (term) begin
               to_d = gnt_q;
               rel = 1'b1;
            end
         end
         HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (term) begin
               to_d = gnt_q;
               rel = 1'b1;
            end else if (bus.req_i[ptr_q]) begin
               addr_d = bus.slave_addr_rw_i[int'(ptr_q)*ADDR_SIZE +: ADDR_SIZE];
               lock_d = bus.lock_i[ptr_q];
               en_d = 1'b1;
               rs_d = 1'b1;
               cnt_d = '0;
               state_d = ACTIVE;
            end else rel = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (rel) begin
         stop_d = 1'b1;
         gnt_d = '0;
         cnt_d = '0;
         state_d = IDLE;
      end
   end
   always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         ptr_q <= PW'(NUM_REQ - 1);
         cnt_q <= '0;
         gnt_q <= '0;
         addr_q <= '0;
         lock_q <= 1'b0;
         en_q <= 1'b0;
         rs_q <= 1'b0;
         stop_q <= 1'b0;
         done_q <= '0;
         nack_q <= '0;
         to_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         gnt_q <= gnt_d;
         addr_q <= addr_d;
         lock_q <= lock_d;
         en_q <= en_d;
         rs_q <= rs_d;
         stop_q <= stop_d;
         done_q <= done_d;
         nack_q <= nack_d;
         to_q <= to_d;
      end
   end
   assign bus.gnt_o = gnt_q;
   assign bus.enable_o = en_q;
   assign bus.repeat_start_o = rs_q;
   assign bus.stop_o = stop_q;
   assign bus.rw_o = addr_q[0];
   assign bus.slave_addr_rw_o = addr_q;
   assign bus.done_o = done_q;
   assign bus.nack_o = nack_q;
   assign bus.timeout_o = to_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: cycle vectors through a scoreboard queue, plus timeout and reset sequences
module tb_i2c_master_arbiter;
   localparam int N = 2, A = 8, TO = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   i2c_master_arbiter_if #(.NUM_REQ(N), .ADDR_SIZE(A)) bus ();
   i2c_master_arbiter #(.NUM_REQ(N), .ADDR_SIZE(A), .TIMEOUT(TO)) dut (
      .i2c_core_clk_i(clk),
      .reset_ni(rst_n),
      .bus(bus)
   );
   typedef struct {
      logic [1:0] req, lock;
      logic [7:0] a0;
      logic done, nack;
      logic [19:0] exp;
   } vec_t;
   vec_t tbl[$];
   logic [19:0] sb[$];
   logic [19:0] got;
   int checks = 0, errors = 0;
   assign got = {bus.gnt_o, bus.enable_o, bus.repeat_start_o, bus.stop_o, bus.rw_o,
                 bus.slave_addr_rw_o, bus.done_o, bus.nack_o, bus.timeout_o};
   function automatic vec_t v(input logic [1:0] req, lock, input logic [7:0] a0, input logic done, nack,
                              input logic [1:0] gnt, input logic en, rs, stop, input logic [7:0] addr,
                              input logic [1:0] dn, nk, to);
      vec_t r;
      r.req = req;
      r.lock = lock;
      r.a0 = a0;
      r.done = done;
      r.nack = nack;
      r.exp = {gnt, en, rs, stop, addr[0], addr, dn, nk, to};
      return r;
   endfunction
   task automatic step(input vec_t r);
      logic [19:0] e;
      bus.req_i = r.req;
      bus.lock_i = r.lock;
      bus.slave_addr_rw_i = {8'h53, r.a0};
      bus.done_i = r.done;
      bus.nack_i = r.nack;
      sb.push_back(r.exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL step%0d got %h exp %h", checks, got, e);
      end
   endtask
   initial begin
      bus.req_i = '0;
      bus.lock_i = '0;
      bus.slave_addr_rw_i = '0;
      bus.done_i = 1'b0;
      bus.nack_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL in_reset got %h exp 0", got);
      end
      rst_n = 1'b1;
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd1, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd1, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd1, 2'd0, 2'd0));
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h53, 2'd2, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd1, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h53, 2'd2, 2'd0, 2'd0));
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd1, 2'd1, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd1, 8'hA0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd1, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'hA1, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA1, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h53, 2'd2, 2'd0, 2'd0));
      tbl.push_back(v(2'd1, 2'd1, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd3, 2'd1, 8'hA0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd1, 2'd1, 2'd0));
      tbl.push_back(v(2'd2, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd2, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h53, 2'd2, 2'd0, 2'd0));
      tbl.push_back(v(2'd2, 2'd2, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd2, 2'd2, 8'hA0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h53, 2'd2, 2'd0, 2'd0));
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h53, 2'd0, 2'd0, 2'd0));
      tbl.push_back(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      foreach (tbl[i]) step(tbl[i]);
      // timeout with no done: pulse exactly TO cycles after the launch
      step(v(2'd1, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      repeat (TO - 1) step(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      step(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd0, 2'd0, 2'd1));
      // done on the terminal cycle beats the timeout
      step(v(2'd2, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      repeat (TO - 1) step(v(2'd0, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h53, 2'd0, 2'd0, 2'd0));
      step(v(2'd0, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h53, 2'd2, 2'd0, 2'd0));
      // asynchronous reset mid-transfer, then requester 0 regains first priority
      step(v(2'd1, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      step(v(2'd1, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL async_reset got %h exp 0", got);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(v(2'd3, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0, 2'd0, 2'd0));
      step(v(2'd0, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd1, 2'd0, 2'd0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Shares one I2C master (master FSM plus clock generator) between NUM_REQ requesters, e.g. the APB register path and a DMA engine. Grants are round-robin and per transaction. A grant can be held across a repeated START, so a write-then-read sequence is never split by another requester. The block drives the master FSM's enable/repeat_start/rw and slave address inputs, and reports completion, NACK and timeout back to the owning requester.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_SIZE, 8, width of slave address + R/W field; bit 0 is R/W (1 = read)
- TIMEOUT, 4096, max i2c_core_clk_i cycles allowed in ACTIVE or HOLD; must be ≥ 2
- i2c_core_clk_i  in  1  i2c core clock; all logic is on its rising edge
- reset_ni  in  1  asynchronous, active-low reset
- req_i  in  NUM_REQ  per-requester transfer request (level)
- slave_addr_rw_i  in  NUM_REQ*ADDR_SIZE  packed per-requester address+R/W; requester r uses bits [r*ADDR_SIZE +: ADDR_SIZE]
- lock_i  in  NUM_REQ  keep the bus after this transfer (repeated START follows)
- done_i  in  1  master FSM: transfer finished (one-cycle pulse)
- nack_i  in  1  master FSM: slave NACKed; qualified by done_i
- gnt_o  out  NUM_REQ  one-hot grant, or all zero
- enable_o  out  1  one-cycle launch pulse to the master FSM
- repeat_start_o  out  1  launch uses a repeated START; valid while enable_o = 1
- stop_o  out  1  one-cycle pulse: master issues STOP / releases the bus
- rw_o  out  1  = slave_addr_rw_o[0]
- slave_addr_rw_o  out  ADDR_SIZE  latched address of the granted requester
- done_o  out  NUM_REQ  one-cycle completion pulse to the owner
- nack_o  out  NUM_REQ  one-cycle pulse: owner's transfer was NACKed
- timeout_o  out  NUM_REQ  one-cycle pulse: owner's transfer aborted by timeout

## Operation
- All outputs are registered. Reset values: every output 0; state IDLE; last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- IDLE: if any req_i is high, pick the first set bit searching upward, with wrap, from pointer+1.
  - Latch gnt, slave_addr_rw and lock for that requester.
  - Set the pointer to it.
  - Pulse enable_o with repeat_start_o = 0.
  - Go to ACTIVE.
- ACTIVE: wait for done_i.
  - On done_i: pulse done_o[g], and nack_o[g] if nack_i = 1.
    - If the latched lock = 1 and nack_i = 0, go to HOLD with gnt kept.
    - Otherwise pulse stop_o, clear gnt_o, go to IDLE.
  - If the timeout counter reaches TIMEOUT-1 with no done_i: pulse timeout_o[g] and stop_o, clear gnt_o, go to IDLE.
- HOLD: bus owned by g, no transfer running.
  - If req_i[g] = 1: relatch address and lock from requester g, pulse enable_o with repeat_start_o = 1, go to ACTIVE.
  - If req_i[g] = 0: pulse stop_o, clear gnt_o, go to IDLE.
  - If the counter reaches TIMEOUT-1: pulse timeout_o[g] and stop_o, go to IDLE.
- Timeout counter: width clog2(TIMEOUT). Cleared on every state entry; increments each cycle in ACTIVE and HOLD; never wraps.
- Boundary rules:
  - done_i in the same cycle as the timeout terminal count: done wins, no timeout_o.
  - req_i[g] dropping during ACTIVE is ignored; the transfer completes.
  - Requests from other requesters while g owns the bus (ACTIVE or HOLD) wait.
  - done_i/nack_i outside ACTIVE are ignored.
  - A NACK always releases the bus, even when lock = 1.
  - Reset asserted mid-transfer clears everything immediately. The master FSM shares reset_ni and aborts in step.

## Timing
- req_i sampled high in IDLE at edge k: from edge k, gnt_o, slave_addr_rw_o, rw_o and enable_o are valid; enable_o is high only for cycle k..k+1.
- done_i high at edge m: done_o/nack_o pulse for cycle m..m+1.
  - Release path: stop_o pulses and gnt_o = 0 from edge m.
  - Hold path: the earliest repeated-START launch is at edge m+1.
- IDLE to next grant: one cycle minimum. Back-to-back transfers by different requesters are separated by ≥ 1 idle cycle.
- At most one of enable_o / stop_o is high in any cycle.

## Test plan
- Single request: req_i = 01, addr 0xA0 → gnt_o = 01, slave_addr_rw_o = 0xA0, rw_o = 0, one enable_o pulse; done_i → done_o = 01, stop_o, gnt_o = 00.
- Contention: req_i = 11 held, done_i after each launch → grants alternate 01, 10, 01, 10; no enable_o while a grant is active.
- Repeated START: req0 with lock = 1, addr 0xA0; on done_i, req0 stays high with addr 0xA1, lock = 0 → second enable_o with repeat_start_o = 1, rw_o = 1, req1 blocked, then stop_o after the second done_i.
- NACK: done_i with nack_i = 1 and lock = 1 → done_o[0] and nack_o[0] pulse, stop_o, bus released, and req1 is granted next cycle.
- Timeout: TIMEOUT = 16, no done_i → timeout_o[g] and stop_o 16 cycles after enable_o; done_i on the terminal cycle → done_o only.
- Reset: drop reset_ni in ACTIVE → all outputs 0 asynchronously; after release, req_i = 11 grants requester 0 first.
